// File: rtl/adder_tree_pkg.sv
// Shared sizing helpers and default dimensions for the pipelined adder tree.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
package adder_tree_pkg;

   localparam int ADDER_TREE_N    = 32;
   localparam int ADDER_TREE_IN_W = 16;

   // Ceiling log2 for v >= 2; gives the number of tree levels.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Width of the partial sums held at tree level l (level 0 = operands).
   function automatic int level_w(input int in_w, input int l);
      return in_w + l;
   endfunction

   // Lossless output width for n operands of in_w bits.
   function automatic int out_w(input int in_w, input int n);
      return in_w + clog2(n);
   endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered tree level: adds COUNT/2 adjacent pairs of W-bit signed values into W+1 bits.
// Latency: 1 cycle.
// Backpressure: stall_i freezes data, valid and last; data only loads for a valid upstream beat.
module adder_tree_level
   import adder_tree_pkg::*;
#(
   parameter int COUNT = 2,
   parameter int W     = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall_i,
   input  logic [COUNT*W-1:0]           dat_i,
   input  logic                         vld_i,
   input  logic                         lst_i,
   output logic [(COUNT/2)*(W+1)-1:0]   dat_o,
   output logic                         vld_o,
   output logic                         lst_o
);

   localparam int PAIRS = COUNT / 2;

   logic [PAIRS*(W+1)-1:0] dat_d;
   logic [PAIRS*(W+1)-1:0] dat_q;
   logic                   vld_q;
   logic                   lst_q;

   // Pairwise signed add, each operand sign-extended by one bit so nothing is lost.
   always_comb begin
      dat_d = '0;
      for (int j = 0; j < PAIRS; j++) begin
         dat_d[j*(W+1) +: (W+1)] =
            {dat_i[2*j*W + W - 1],     dat_i[2*j*W +: W]} +
            {dat_i[(2*j+1)*W + W - 1], dat_i[(2*j+1)*W +: W]};
      end
   end

   // Stage register: hold everything on stall; keep the last valid data across bubbles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dat_q <= '0;
         vld_q <= 1'b0;
         lst_q <= 1'b0;
      end else if (!stall_i) begin
         vld_q <= vld_i;
         lst_q <= lst_i;
         if (vld_i) dat_q <= dat_d;
      end
   end

   assign dat_o = dat_q;
   assign vld_o = vld_q;
   assign lst_o = lst_q;

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree over N operands (zero-padded to a power of two); ADDER_TREE_ACC_EN adds a multi-beat accumulator.
// Latency: LEVELS cycles, or LEVELS+1 with ADDER_TREE_ACC_EN.
// Backpressure: in_ready = ~(out_valid & ~out_ready); a stall freezes every stage, no bubble compression.
module pipelined_adder_tree
   import adder_tree_pkg::*;
#(
   parameter  int N      = ADDER_TREE_N,
   parameter  int IN_W   = ADDER_TREE_IN_W,
   localparam int LEVELS = clog2(N),
   localparam int OUT_W  = out_w(IN_W, N)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N*IN_W-1:0]   in_data,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic [OUT_W-1:0]    out_sum,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int P = 1 << LEVELS;

   logic                stall;
   logic [P*IN_W-1:0]   pad_dat;
   logic [OUT_W-1:0]    tree_dat;
   logic                tree_vld;
   logic                tree_lst;

   // Operands beyond N are tied to zero so the tree is always a full binary tree.
   always_comb begin
      pad_dat = '0;
      pad_dat[N*IN_W-1:0] = in_data;
   end

   for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
      localparam int CNT = P >> (l - 1);
      localparam int W   = level_w(IN_W, l - 1);

      logic [(CNT/2)*(W+1)-1:0] dat;
      logic                     vld;
      logic                     lst;

      if (l == 1) begin : g_first
         adder_tree_level #(.COUNT(CNT), .W(W)) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall_i (stall),
            .dat_i   (pad_dat),
            .vld_i   (in_valid),
            .lst_i   (in_last),
            .dat_o   (dat),
            .vld_o   (vld),
            .lst_o   (lst)
         );
      end else begin : g_next
         adder_tree_level #(.COUNT(CNT), .W(W)) u_level (
            .clk     (clk),
            .rst_n   (rst_n),
            .stall_i (stall),
            .dat_i   (g_lvl[l-1].dat),
            .vld_i   (g_lvl[l-1].vld),
            .lst_i   (g_lvl[l-1].lst),
            .dat_o   (dat),
            .vld_o   (vld),
            .lst_o   (lst)
         );
      end
   end

   assign tree_dat = g_lvl[LEVELS].dat;
   assign tree_vld = g_lvl[LEVELS].vld;
   assign tree_lst = g_lvl[LEVELS].lst;

`ifdef ADDER_TREE_ACC_EN
   localparam int ACC_W = OUT_W + 8;

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] acc_tot;
   logic [OUT_W-1:0] sum_q, sum_d;
   logic             vld_q, vld_d;

   assign acc_tot = acc_q + {{8{tree_dat[OUT_W-1]}}, tree_dat};
   assign stall   = vld_q & ~out_ready;

   // Accumulate every tree result; release and clear the total on the beat tagged last.
   always_comb begin
      acc_d = acc_q;
      sum_d = sum_q;
      vld_d = vld_q;
      if (!stall) begin
         vld_d = 1'b0;
         if (tree_vld) begin
            if (tree_lst) begin
               sum_d = acc_tot[OUT_W-1:0];
               vld_d = 1'b1;
               acc_d = '0;
            end else begin
               acc_d = acc_tot;
            end
         end
      end
   end

   // Accumulator and output register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         sum_q <= '0;
         vld_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         sum_q <= sum_d;
         vld_q <= vld_d;
      end
   end

   assign out_sum   = sum_q;
   assign out_valid = vld_q;
`else
   logic unused_last;

   // The last tag has no consumer when every beat produces its own output.
   assign unused_last = tree_lst;
   assign stall       = tree_vld & ~out_ready;
   assign out_sum     = tree_dat;
   assign out_valid   = tree_vld;
`endif

   assign in_ready = ~stall;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
module tb_pipelined_adder_tree;

   localparam int N      = 32;
   localparam int IN_W   = 16;
   localparam int LEVELS = 5;
   localparam int OUT_W  = 21;
   localparam int N5     = 5;
   localparam int OUT_W5 = 19;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n;
   logic [N*IN_W-1:0]   in_data;
   logic                in_valid, in_last, in_ready;
   logic [OUT_W-1:0]    out_sum;
   logic                out_valid, out_ready;

   logic [N5*IN_W-1:0]  in_data5;
   logic                in_valid5, in_ready5, out_valid5;
   logic [OUT_W5-1:0]   out_sum5;

   pipelined_adder_tree #(.N(N), .IN_W(IN_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_sum(out_sum),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   pipelined_adder_tree #(.N(N5), .IN_W(IN_W)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5),
      .in_last(1'b0), .in_ready(in_ready5), .out_sum(out_sum5),
      .out_valid(out_valid5), .out_ready(1'b1)
   );

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: actual %0d required %0d", name, act, exp);
   endtask

   // Reference: plain signed sum of the N operands.
   function automatic longint model_sum(input logic [N*IN_W-1:0] d);
      longint s = 0;
      for (int k = 0; k < N; k++) s += longint'($signed(d[k*IN_W +: IN_W]));
      return s;
   endfunction

   function automatic logic [N*IN_W-1:0] all_ops(input logic [IN_W-1:0] v);
      logic [N*IN_W-1:0] r;
      for (int k = 0; k < N; k++) r[k*IN_W +: IN_W] = v;
      return r;
   endfunction

   function automatic logic [N*IN_W-1:0] rand_beat();
      logic [N*IN_W-1:0] r;
      int sel = $urandom_range(0, 7);
      for (int k = 0; k < N; k++) r[k*IN_W +: IN_W] = IN_W'($urandom);
      if (sel == 0) r = all_ops(16'h8000);
      if (sel == 1) r = all_ops(16'h7FFF);
      return r;
   endfunction

   // Scoreboard: every consumed output must match the oldest accepted beat; stalls must hold.
   longint            exp_q[$];
   int                delivered = 0;
   logic              held_vld  = 1'b0;
   logic [OUT_W-1:0]  held_sum;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         held_vld = 1'b0;
      end else begin
         check("in_ready_rule", in_ready, !(out_valid && !out_ready));
         if (held_vld) begin
            check("stall_valid_hold", out_valid, 1);
            check("stall_sum_hold", out_sum, held_sum);
         end
         if (out_valid && out_ready) begin
            check("spurious_output", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               check("scoreboard_sum", $signed(out_sum), exp_q.pop_front());
               delivered++;
            end
         end
         held_vld = out_valid && !out_ready;
         held_sum = out_sum;
         if (in_valid && in_ready) exp_q.push_back(model_sum(in_data));
      end
   end

   // Present one beat and hold it until accepted; returns the number of cycles it took.
   task automatic send(input logic [N*IN_W-1:0] d, output int tries);
      logic ok;
      tries    = 0;
      in_data  = d;
      in_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         tries++;
      end while (!ok && tries < 200);
      check("send_accept", ok, 1);
      in_valid = 1'b0;
   endtask

   // Send a single beat on an idle pipe and check latency and value against a literal.
   task automatic single(input logic [N*IN_W-1:0] d, input string name, input longint exp_lit);
      int t, lat;
      send(d, t);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check({name, "_latency"}, lat, LEVELS);
      check({name, "_sum"}, $signed(out_sum), exp_lit);
   endtask

   task automatic drain();
      repeat (12) @(posedge clk);
      #1;
   endtask

   logic rnd_done;

   initial begin
      int t, lat, d0;
      rst_n     = 1'b0;
      in_data   = '0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      in_data5  = '0;
      in_valid5 = 1'b0;
      rnd_done  = 1'b0;

      // Model pins.
      check("model_pin_ones", model_sum(all_ops(16'h0001)), 32);
      check("model_pin_min", model_sum(all_ops(16'h8000)), -1048576);

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_sum", out_sum, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Single beat of ones: 32 after 5 cycles, valid for exactly one cycle, value held after.
      single(all_ops(16'h0001), "ones", 32);
      @(negedge clk);
      check("ones_valid_pulse", out_valid, 0);
      check("ones_sum_held", $signed(out_sum), 32);
      drain();

      // Extremes: no overflow.
      single(all_ops(16'h8000), "all_min", -1048576);
      drain();
      single(all_ops(16'h7FFF), "all_max", 1048544);
      drain();

      // Back-to-back beats, operands equal to the beat index.
      d0 = delivered;
      for (int b = 0; b < 8; b++) begin
         send(all_ops(IN_W'(b)), t);
         check("cont_in_ready", t, 1);
      end
      drain();
      check("cont_delivered", delivered - d0, 8);

      // Stall for 4 cycles with the pipe full.
      d0 = delivered;
      fork
         begin
            for (int b = 0; b < 10; b++) send(all_ops(IN_W'(b * 3 + 1)), t);
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) begin
               @(negedge clk);
               check("stall_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("stall_delivered", delivered - d0, 10);

      // Randomised traffic with gaps and random back-pressure.
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end else begin
                  send(rand_beat(), t);
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      out_ready = 1'b1;
      drain();
      check("random_drained", exp_q.size(), 0);

      // Reset mid-flight discards everything.
      for (int b = 0; b < 3; b++) send(all_ops(16'h0005), t);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check("reset_flush_valid", out_valid, 0);
      end
      check("reset_flush_sum", out_sum, 0);
      @(posedge clk);
      #1;

      // N=5 padded to 8: operands 1..5 give 15 after 3 cycles.
      for (int k = 0; k < N5; k++) in_data5[k*IN_W +: IN_W] = IN_W'(k + 1);
      in_valid5 = 1'b1;
      @(negedge clk);
      check("n5_in_ready", in_ready5, 1);
      @(posedge clk);
      #1 in_valid5 = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid5 && lat < 20);
      check("n5_latency", lat, 3);
      check("n5_sum", $signed(out_sum5), 15);
      drain();

      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, %0d/%0d so far", passed, checks);
      $fatal(1, "watchdog");
   end

endmodule
